uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, 2-flop input synchronizer.
// Reports each frame with a one-clk done pulse and a stop-bit error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          rx_m, rx_s;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // armed drops when a frame ends on a low line (break), so a held-low
  // line yields one frame and waits for a fresh high-to-low edge.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    armed_d = armed_q | rx_s;
    unique case (state_q)
      IDLE: begin
        if (!rx_s && armed_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(7)) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == 3'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
            armed_d = rx_s;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = b_q >> (8 - DBIT);
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule
